// File: rtl/ovl_sem_pkg.sv
// Shared types and helpers for the OVL semantic pulse scheduler.
package ovl_sem_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEAD,
      HIGH,
      GAP,
      DRAIN
   } sched_state_e;

   // Bit of the checker fire vector that flags an assertion failure.
   localparam int OVL_FIRE_2STATE = 0;

   // Increment that sticks at the all-ones value of a 'width'-bit field.
   function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
      logic [31:0] max_val;
      max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      return (val >= max_val) ? max_val : (val + 32'd1);
   endfunction

endpackage

// File: rtl/ovl_sem_phase_cnt.sv
// Loadable down-counter timing one scheduler phase (lead, width, gap or drain).
// expired is high during the last cycle of the loaded phase length.
module ovl_sem_phase_cnt #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         zero_as_one,
   input  logic         dec,
   input  logic [W-1:0] load_val,
   output logic         expired
);

   logic [W-1:0] cnt;

   // Load has priority over decrement; a zero load may be promoted to one cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= (zero_as_one && (load_val == '0)) ? W'(1) : load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - W'(1);
      end
   end

   assign expired = (cnt <= W'(1));

endmodule

// File: rtl/ovl_sem_pulse_sched.sv
// Pulse-train sequencer driving an ovl_width-style checker and recording its fire bit.
module ovl_sem_pulse_sched
   import ovl_sem_pkg::*;
#(
   parameter int CNT_W     = 4,
   parameter int CYC_W     = 8,
   parameter int DRAIN_CKS = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [CNT_W-1:0] cfg_lead,
   input  logic [CNT_W-1:0] cfg_width,
   input  logic [CNT_W-1:0] cfg_gap,
   input  logic [CNT_W-1:0] cfg_count,
   input  logic [2:0]       fire,
   output logic             enable,
   output logic             test_expr,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] fire_cnt,
   output logic [CYC_W-1:0] first_fire_cycle
);

   localparam logic [CNT_W-1:0] DRAIN_VAL = CNT_W'(DRAIN_CKS);

   sched_state_e     state;
   logic [CNT_W-1:0] width_q;
   logic [CNT_W-1:0] gap_q;
   logic [CNT_W-1:0] pulses_left;
   logic [CYC_W-1:0] run_cyc;
   logic             hit;
   logic             accept;
   logic             ph_load;
   logic             ph_dec;
   logic [CNT_W-1:0] ph_val;
   logic             ph_expired;
   logic             unused_fire_hi;

   // A start is only honoured in IDLE and not in the done cycle.
   assign accept         = (state == IDLE) && start && !done;
   assign unused_fire_hi = ^fire[2:1];

   // Phase counter control: reload on every phase change, count down otherwise.
   always_comb begin
      ph_load = 1'b0;
      ph_dec  = 1'b0;
      ph_val  = '0;
      case (state)
         IDLE: begin
            if (accept) begin
               ph_load = 1'b1;
               if (cfg_lead != '0)       ph_val = cfg_lead;
               else if (cfg_count != '0) ph_val = cfg_width;
               else                      ph_val = DRAIN_VAL;
            end
         end
         LEAD: begin
            if (ph_expired) begin
               ph_load = 1'b1;
               ph_val  = (pulses_left != '0) ? width_q : DRAIN_VAL;
            end else begin
               ph_dec = 1'b1;
            end
         end
         HIGH: begin
            if (ph_expired) begin
               ph_load = 1'b1;
               ph_val  = (pulses_left > CNT_W'(1)) ? gap_q : DRAIN_VAL;
            end else begin
               ph_dec = 1'b1;
            end
         end
         GAP: begin
            if (ph_expired) begin
               ph_load = 1'b1;
               ph_val  = width_q;
            end else begin
               ph_dec = 1'b1;
            end
         end
         DRAIN: begin
            ph_dec = !ph_expired;
         end
         default: ;
      endcase
   end

   ovl_sem_phase_cnt #(
      .W (CNT_W)
   ) u_phase_cnt (
      .clk         (clk),
      .reset       (reset),
      .load        (ph_load),
      .zero_as_one (1'b1),
      .dec         (ph_dec),
      .load_val    (ph_val),
      .expired     (ph_expired)
   );

   // Run configuration: captured on the accepted start, pulses consumed as each HIGH ends.
   always_ff @(posedge clk) begin
      if (accept) begin
         width_q     <= cfg_width;
         gap_q       <= cfg_gap;
         pulses_left <= cfg_count;
      end else if ((state == HIGH) && ph_expired) begin
         pulses_left <= pulses_left - CNT_W'(1);
      end
   end

   // Scheduler FSM with registered enable/test_expr/busy/done.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         busy      <= 1'b0;
         test_expr <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  busy <= 1'b1;
                  if (cfg_lead != '0) begin
                     state <= LEAD;
                  end else if (cfg_count != '0) begin
                     state     <= HIGH;
                     test_expr <= 1'b1;
                  end else begin
                     state <= DRAIN;
                  end
               end
            end
            LEAD: begin
               if (ph_expired) begin
                  if (pulses_left != '0) begin
                     state     <= HIGH;
                     test_expr <= 1'b1;
                  end else begin
                     state <= DRAIN;
                  end
               end
            end
            HIGH: begin
               if (ph_expired) begin
                  test_expr <= 1'b0;
                  state     <= (pulses_left > CNT_W'(1)) ? GAP : DRAIN;
               end
            end
            GAP: begin
               if (ph_expired) begin
                  state     <= HIGH;
                  test_expr <= 1'b1;
               end
            end
            DRAIN: begin
               if (ph_expired) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               busy      <= 1'b0;
               test_expr <= 1'b0;
            end
         endcase
      end
   end

   assign enable = busy;

   // Fire monitor: counts fire[0] cycles and stamps the first hit while a run is active.
   always_ff @(posedge clk) begin
      if (reset) begin
         fire_cnt         <= '0;
         first_fire_cycle <= '1;
         hit              <= 1'b0;
         run_cyc          <= '0;
      end else if (accept) begin
         fire_cnt         <= '0;
         first_fire_cycle <= '1;
         hit              <= 1'b0;
         run_cyc          <= '0;
      end else if (busy) begin
         run_cyc <= CYC_W'(sat_inc(32'(run_cyc), CYC_W));
         if (fire[OVL_FIRE_2STATE]) begin
            fire_cnt <= CNT_W'(sat_inc(32'(fire_cnt), CNT_W));
            if (!hit) begin
               first_fire_cycle <= run_cyc;
               hit              <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_ovl_sem_pulse_sched.sv
// Self-checking bench for ovl_sem_pulse_sched: queue-based schedule model plus literal pins.
module tb_ovl_sem_pulse_sched;

   localparam int CNT_W     = 4;
   localparam int CYC_W     = 8;
   localparam int DRAIN_CKS = 4;
   localparam int CNT_MAX   = (1 << CNT_W) - 1;
   localparam int CYC_MAX   = (1 << CYC_W) - 1;
   localparam int W_MIN     = 2;
   localparam int W_MAX     = 2;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic [CNT_W-1:0] cfg_lead, cfg_width, cfg_gap, cfg_count;
   logic [2:0]       fire;
   logic [1:0]       fire_hi;
   logic             fire_force;
   logic             chk_en;
   logic             chk_fire;
   logic             enable, test_expr, busy, done;
   logic [CNT_W-1:0] fire_cnt;
   logic [CYC_W-1:0] first_fire_cycle;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   ovl_sem_pulse_sched #(
      .CNT_W     (CNT_W),
      .CYC_W     (CYC_W),
      .DRAIN_CKS (DRAIN_CKS)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .start            (start),
      .cfg_lead         (cfg_lead),
      .cfg_width        (cfg_width),
      .cfg_gap          (cfg_gap),
      .cfg_count        (cfg_count),
      .fire             (fire),
      .enable           (enable),
      .test_expr        (test_expr),
      .busy             (busy),
      .done             (done),
      .fire_cnt         (fire_cnt),
      .first_fire_cycle (first_fire_cycle)
   );

   // Simple ovl_width checker (min=max=2) fed by the DUT's test_expr
   int chk_run = 0;
   always @(posedge clk) begin
      if (reset || !test_expr) chk_run <= 0;
      else                     chk_run <= chk_run + 1;
   end
   assign chk_fire = (test_expr && chk_run >= W_MAX) ||
                     (!test_expr && chk_run > 0 && chk_run < W_MIN);
   assign fire = {fire_hi, chk_en ? chk_fire : fire_force};

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a run is a queue of expected test_expr values
   bit m_q[$];
   bit m_busy = 0, m_done = 0, m_hit = 0;
   int m_fcnt = 0, m_first = CYC_MAX, m_cyc = 0;

   always @(posedge clk) begin : model
      bit pd;
      int w, g;
      if (reset) begin
         m_q.delete();
         m_busy = 0; m_done = 0; m_hit = 0;
         m_fcnt = 0; m_first = CYC_MAX; m_cyc = 0;
      end else begin
         if (m_busy) begin
            if (fire[0]) begin
               if (m_fcnt < CNT_MAX) m_fcnt++;
               if (!m_hit) begin m_first = m_cyc; m_hit = 1; end
            end
            if (m_cyc < CYC_MAX) m_cyc++;
         end
         pd = m_done;
         m_done = 0;
         if (m_busy) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) begin m_busy = 0; m_done = 1; end
         end else if (start && !pd) begin
            w = (cfg_width == 0) ? 1 : int'(cfg_width);
            g = (cfg_gap == 0) ? 1 : int'(cfg_gap);
            for (int i = 0; i < int'(cfg_lead); i++) m_q.push_back(1'b0);
            for (int p = 0; p < int'(cfg_count); p++) begin
               for (int i = 0; i < w; i++) m_q.push_back(1'b1);
               if (p < int'(cfg_count) - 1)
                  for (int i = 0; i < g; i++) m_q.push_back(1'b0);
            end
            for (int i = 0; i < DRAIN_CKS; i++) m_q.push_back(1'b0);
            m_busy = 1; m_fcnt = 0; m_first = CYC_MAX; m_hit = 0; m_cyc = 0;
         end
      end
   end

   // Observation history for the literal expectations
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   bit cmp_on = 0;
   bit armed  = 0;
   int t_cyc  = 0;
   bit te_hist [0:63];
   bit dn_hist [0:63];
   int busy_cnt, en_cnt, te_cnt, done_cnt;

   task automatic clr();
      for (int i = 0; i < 64; i++) begin te_hist[i] = 0; dn_hist[i] = 0; end
      busy_cnt = 0; en_cnt = 0; te_cnt = 0; done_cnt = 0;
   endtask

   // Per-cycle compare against the model, plus history capture
   always @(negedge clk) begin
      int idx;
      if (cmp_on) begin
         check("enable", int'(enable), int'(m_busy));
         check("busy", int'(busy), int'(m_busy));
         check("test_expr", int'(test_expr), m_busy ? int'(m_q[0]) : 0);
         check("done", int'(done), int'(m_done));
         check("fire_cnt", int'(fire_cnt), m_fcnt);
         check("first_fire_cycle", int'(first_fire_cycle), m_first);
      end
      if (armed) begin
         idx = cyc - t_cyc + 1;
         if (idx >= 0 && idx < 64) begin
            te_hist[idx] = test_expr;
            dn_hist[idx] = done;
         end
         busy_cnt += int'(busy);
         en_cnt   += int'(enable);
         te_cnt   += int'(test_expr);
         done_cnt += int'(done);
      end
   end

   task automatic start_run(input int l, input int w, input int g, input int c);
      @(posedge clk); #1;
      cfg_lead = CNT_W'(l); cfg_width = CNT_W'(w); cfg_gap = CNT_W'(g); cfg_count = CNT_W'(c);
      start = 1'b1;
      armed = 0;
      clr();
      @(posedge clk); #1;
      start = 1'b0;
      t_cyc = cyc;
      armed = 1;
   endtask

   task automatic wait_done(input string name, input int limit);
      bit got = 0;
      for (int k = 0; k < limit; k++) begin
         @(negedge clk);
         if (done) begin got = 1; break; end
      end
      check(name, int'(got), 1);
      repeat (3) @(negedge clk);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      reset = 1'b1; start = 1'b1;
      cfg_lead = 4'd1; cfg_width = 4'd3; cfg_gap = 4'd1; cfg_count = 4'd1;
      fire_hi = 2'b00; fire_force = 1'b0; chk_en = 1'b0;
      clr();

      // 1: reset with start held
      @(posedge clk); #1;
      cmp_on = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_busy", int'(busy), 0);
         check("rst_enable", int'(enable), 0);
         check("rst_test_expr", int'(test_expr), 0);
         check("rst_done", int'(done), 0);
         check("rst_fire_cnt", int'(fire_cnt), 0);
         check("rst_first_fire", int'(first_fire_cycle), 8'hFF);
      end
      @(posedge clk); #1;
      reset = 1'b0; start = 1'b0;
      repeat (2) @(posedge clk);

      // 2: width 3 against a width-2 checker
      chk_en = 1'b1;
      start_run(1, 3, 1, 1);
      wait_done("t2_done_seen", 50);
      check("t2_te_T1", int'(te_hist[1]), 0);
      check("t2_te_T2", int'(te_hist[2]), 1);
      check("t2_te_T3", int'(te_hist[3]), 1);
      check("t2_te_T4", int'(te_hist[4]), 1);
      check("t2_te_T5", int'(te_hist[5]), 0);
      check("t2_done_T9", int'(dn_hist[9]), 1);
      check("t2_busy_cycles", busy_cnt, 8);
      check("t2_fire_cnt_ge1", int'(fire_cnt >= 1), 1);
      check("t2_first_fire", int'(first_fire_cycle), 3);

      // 3: width 2 satisfies the checker
      start_run(1, 2, 1, 1);
      wait_done("t3_done_seen", 50);
      check("t3_fire_cnt", int'(fire_cnt), 0);
      check("t3_first_fire", int'(first_fire_cycle), 8'hFF);
      check("t3_done_once", done_cnt, 1);

      // 4: zero width/gap promoted to one, three pulses
      chk_en = 1'b0; fire_force = 1'b0;
      start_run(0, 0, 0, 3);
      wait_done("t4_done_seen", 50);
      check("t4_te_T1", int'(te_hist[1]), 1);
      check("t4_te_T2", int'(te_hist[2]), 0);
      check("t4_te_T3", int'(te_hist[3]), 1);
      check("t4_te_T4", int'(te_hist[4]), 0);
      check("t4_te_T5", int'(te_hist[5]), 1);
      check("t4_busy_cycles", busy_cnt, 9);
      check("t4_done_once", done_cnt, 1);

      // 4b: fire[0] held through the run, upper fire bits set
      fire_force = 1'b1; fire_hi = 2'b11;
      start_run(0, 0, 0, 3);
      wait_done("t4b_done_seen", 50);
      check("t4b_fire_cnt", int'(fire_cnt), 9);
      check("t4b_first_fire", int'(first_fire_cycle), 0);

      // 4c: only the ignored fire bits active
      fire_force = 1'b0;
      start_run(0, 0, 0, 3);
      wait_done("t4c_done_seen", 50);
      check("t4c_fire_cnt", int'(fire_cnt), 0);
      fire_hi = 2'b00;

      // 5: count 0 with lead 2; mid-run config change and start are ignored
      start_run(2, 5, 5, 0);
      @(posedge clk); #1;
      cfg_lead = 4'd0; cfg_width = 4'd1; cfg_gap = 4'd1; cfg_count = 4'd7;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done("t5_done_seen", 50);
      check("t5_te_high_cycles", te_cnt, 0);
      check("t5_enable_cycles", en_cnt, 6);
      check("t5_done_once", done_cnt, 1);

      // start held high across a run end: ignored in the done cycle, then a second run
      @(posedge clk); #1;
      cfg_lead = 4'd0; cfg_width = 4'd1; cfg_gap = 4'd1; cfg_count = 4'd1;
      clr(); t_cyc = cyc; armed = 1;
      start = 1'b1;
      repeat (12) @(posedge clk);
      #1 start = 1'b0;
      wait_done("hold_done_seen", 50);
      check("hold_done_twice", done_cnt, 2);

      // run-cycle and fire-count saturation over a long run
      start_run(15, 15, 15, 15);
      repeat (300) @(posedge clk);
      #1 fire_force = 1'b1;
      wait_done("sat_done_seen", 400);
      check("sat_fire_cnt", int'(fire_cnt), 15);
      check("sat_first_fire", int'(first_fire_cycle), 8'hFF);
      check("sat_busy_cycles", busy_cnt, 454);
      fire_force = 1'b0;

      // 6: reset in the middle of a HIGH phase
      start_run(0, 8, 1, 1);
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      clr();
      @(negedge clk);
      check("t6_enable", int'(enable), 0);
      check("t6_test_expr", int'(test_expr), 0);
      check("t6_busy", int'(busy), 0);
      check("t6_done", int'(done), 0);
      repeat (10) @(negedge clk);
      check("t6_no_done", done_cnt, 0);
      start_run(1, 2, 1, 2);
      wait_done("t6_rerun_done_seen", 50);
      check("t6_rerun_done_once", done_cnt, 1);
      check("t6_rerun_busy_cycles", busy_cnt, 10);

      armed = 0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
